// File: rtl/stack_pointer_bank.sv
// stack_pointer_bank: banked, bounds-checked, downward-growing stack pointers.
// Each of NCTX contexts owns a W-bit SP, inclusive lo/hi limits and sticky
// overflow/underflow flags. Push/pop move the SP by a variable byte count.
// Optional feature macro: STACK_SP_WATERMARK_EN adds a per-context low-water
// mark register and the wm_q output port.
module stack_pointer_bank #(
    parameter int W = 16,
    parameter int NCTX = 2,
    parameter logic [W-1:0] RESET_SP = '0,
    localparam int CW = (NCTX > 1) ? $clog2(NCTX) : 1,
    localparam int SZW = $clog2(W / 8) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [CW-1:0]  ctx,
    input  logic           ld,
    input  logic           push,
    input  logic           pop,
    input  logic [SZW-1:0] nbytes,
    input  logic [W-1:0]   d,
    input  logic           cfg_we,
    input  logic [CW-1:0]  cfg_ctx,
    input  logic [W-1:0]   cfg_lo,
    input  logic [W-1:0]   cfg_hi,
    input  logic           flt_clr,
    output logic [W-1:0]   q,
    output logic           ovf,
    output logic           unf,
    output logic           busy_err
`ifdef STACK_SP_WATERMARK_EN
    ,
    output logic [W-1:0]   wm_q
`endif
);

    logic [W-1:0]    r_sp [NCTX];
    logic [W-1:0]    r_lo [NCTX];
    logic [W-1:0]    r_hi [NCTX];
    logic [NCTX-1:0] r_ovf;
    logic [NCTX-1:0] r_unf;
    logic            r_busyErr;

    logic [CW-1:0]   w_ctxEff;
    logic [CW-1:0]   w_cfgCtxEff;
    logic [W-1:0]    w_nEff;
    logic [W-1:0]    w_spCur;
    logic [W:0]      w_sub;
    logic [W:0]      w_add;
    logic            w_pushRej;
    logic            w_popRej;
    logic [W-1:0]    w_spNext;
    logic            w_setOvf;
    logic            w_setUnf;
    logic            w_spLowered;

    // Fold out-of-range context selects onto context 0 and normalise the byte count
    always_comb begin
        w_ctxEff    = (int'(ctx) < NCTX) ? ctx : '0;
        w_cfgCtxEff = (int'(cfg_ctx) < NCTX) ? cfg_ctx : '0;
        if ((nbytes == '0) || (int'(nbytes) > (W / 8))) begin
            w_nEff = W'(W / 8);
        end else begin
            w_nEff = W'(nbytes);
        end
    end

    // Both candidate results are formed one bit wider so wrap-around shows up as the MSB
    always_comb begin
        w_spCur   = r_sp[w_ctxEff];
        w_sub     = {1'b0, w_spCur} - {1'b0, w_nEff};
        w_add     = {1'b0, w_spCur} + {1'b0, w_nEff};
        w_pushRej = w_sub[W] | (w_sub[W-1:0] < r_lo[w_ctxEff]);
        w_popRej  = w_add[W] | (w_add[W-1:0] > r_hi[w_ctxEff]);
    end

    // Operation priority: load beats a push/pop pair, which cancels, then push, then pop
    always_comb begin
        w_spNext    = w_spCur;
        w_setOvf    = 1'b0;
        w_setUnf    = 1'b0;
        w_spLowered = 1'b0;
        if (ld) begin
            w_spNext    = d;
            w_spLowered = 1'b1;
        end else if (push && pop) begin
            w_spNext = w_spCur;
        end else if (push) begin
            if (w_pushRej) begin
                w_setOvf = 1'b1;
            end else begin
                w_spNext    = w_sub[W-1:0];
                w_spLowered = 1'b1;
            end
        end else if (pop) begin
            if (w_popRej) begin
                w_setUnf = 1'b1;
            end else begin
                w_spNext = w_add[W-1:0];
            end
        end
    end

    // Bank state update; a fault set in the same cycle as a clear leaves the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCTX; i++) begin
                r_sp[i] <= RESET_SP;
                r_lo[i] <= '0;
                r_hi[i] <= RESET_SP;
            end
            r_ovf     <= '0;
            r_unf     <= '0;
            r_busyErr <= 1'b0;
        end else begin
            r_sp[w_ctxEff] <= w_spNext;
            if (flt_clr) begin
                r_ovf[w_ctxEff] <= 1'b0;
                r_unf[w_ctxEff] <= 1'b0;
            end
            if (w_setOvf) begin
                r_ovf[w_ctxEff] <= 1'b1;
            end
            if (w_setUnf) begin
                r_unf[w_ctxEff] <= 1'b1;
            end
            if (cfg_we) begin
                r_lo[w_cfgCtxEff] <= cfg_lo;
                r_hi[w_cfgCtxEff] <= cfg_hi;
            end
            r_busyErr <= w_setOvf | w_setUnf;
        end
    end

    assign q        = r_sp[w_ctxEff];
    assign ovf      = r_ovf[w_ctxEff];
    assign unf      = r_unf[w_ctxEff];
    assign busy_err = r_busyErr;

`ifdef STACK_SP_WATERMARK_EN
    logic [W-1:0] r_wm [NCTX];

    // Track the deepest SP reached; a fault clear rebases the mark on the post-edge SP
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCTX; i++) begin
                r_wm[i] <= RESET_SP;
            end
        end else begin
            if (w_spLowered && (w_spNext < r_wm[w_ctxEff])) begin
                r_wm[w_ctxEff] <= w_spNext;
            end
            if (flt_clr) begin
                r_wm[w_ctxEff] <= w_spNext;
            end
        end
    end

    assign wm_q = r_wm[w_ctxEff];
`endif

endmodule
